// File: rtl/pam4_tx_ffe.sv
// PAM4 transmit FFE: Gray-index to level map, programmable pre/main/post FIR, saturated output.
// Build option: define PAM4_TX_FFE_PRECURSOR_EN for the 3-tap form; otherwise main/post only.
module pam4_tx_ffe #(
  parameter int COEF_W   = 8,
  parameter int OUT_W    = 10,
  parameter int MAIN_RST = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          symbol_in,
  input  logic                symbol_in_valid,
  input  logic [COEF_W-1:0]   coef_pre,
  input  logic [COEF_W-1:0]   coef_main,
  input  logic [COEF_W-1:0]   coef_post,
  input  logic                coef_load,
  output logic                coef_pending,
  output logic [OUT_W-1:0]    sample_out,
  output logic                sample_out_valid,
  output logic                sat
);

  localparam int PROD_W = COEF_W + 2;
`ifdef PAM4_TX_FFE_PRECURSOR_EN
  localparam int SUM_W  = COEF_W + 4;
`else
  localparam int SUM_W  = COEF_W + 3;
`endif
  localparam int EXT_W  = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

  localparam logic [COEF_W-1:0]        MAIN_RST_C = COEF_W'(MAIN_RST);
  localparam logic signed [EXT_W-1:0]  SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0]  SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Levels only reach +/-3, so COEF_W+2 bits always hold the exact product.
  function automatic logic signed [PROD_W-1:0] tap_mul(input logic [COEF_W-1:0] c,
                                                       input logic signed [2:0] l);
    logic signed [PROD_W-1:0] c_ext;
    logic signed [PROD_W-1:0] l_ext;
    c_ext = {{2{c[COEF_W-1]}}, c};
    l_ext = {{(PROD_W-3){l[2]}}, l};
    return c_ext * l_ext;
  endfunction

  function automatic logic signed [SUM_W-1:0] to_sum(input logic signed [PROD_W-1:0] p);
    return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  logic signed [2:0]        w_x;
  logic signed [2:0]        r_d1;
  logic [COEF_W-1:0]        r_c_main;
  logic [COEF_W-1:0]        r_c_post;
  logic [COEF_W-1:0]        r_s_main;
  logic [COEF_W-1:0]        r_s_post;
  logic                     r_pending;
  logic [OUT_W-1:0]         r_sample;
  logic                     r_valid;
  logic                     r_sat;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [EXT_W-1:0]  w_sum_ext;
  logic                     w_hi;
  logic                     w_lo;
  logic [OUT_W-1:0]         w_clip;

`ifdef PAM4_TX_FFE_PRECURSOR_EN
  logic signed [2:0]        r_d2;
  logic [COEF_W-1:0]        r_c_pre;
  logic [COEF_W-1:0]        r_s_pre;
`else
  logic                     w_unused_pre;
  assign w_unused_pre = ^coef_pre;
`endif

  // 2*idx-3 in 3-bit two's complement is {~idx[1], idx[0], 1}.
  assign w_x = {~symbol_in[1], symbol_in[0], 1'b1};

`ifdef PAM4_TX_FFE_PRECURSOR_EN
  assign w_sum = to_sum(tap_mul(r_c_pre, w_x)) + to_sum(tap_mul(r_c_main, r_d1))
               + to_sum(tap_mul(r_c_post, r_d2));
`else
  assign w_sum = to_sum(tap_mul(r_c_main, w_x)) + to_sum(tap_mul(r_c_post, r_d1));
`endif

  assign w_sum_ext = {{(EXT_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};
  assign w_hi      = (w_sum_ext > SAT_MAX);
  assign w_lo      = (w_sum_ext < SAT_MIN);

  always_comb begin
    w_clip = w_sum_ext[OUT_W-1:0];
    if (w_hi) begin
      w_clip = SAT_MAX[OUT_W-1:0];
    end else if (w_lo) begin
      w_clip = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_d1     <= '0;
`ifdef PAM4_TX_FFE_PRECURSOR_EN
      r_d2     <= '0;
`endif
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_valid <= symbol_in_valid;
      if (symbol_in_valid) begin
        r_sample <= w_clip;
        r_sat    <= w_hi | w_lo;
        r_d1     <= w_x;
`ifdef PAM4_TX_FFE_PRECURSOR_EN
        r_d2     <= r_d1;
`endif
      end
    end
  end

  // Shadow taps go live on the edge of the first valid after the load, so that
  // symbol still sees the old taps; a load in the same cycle refills the shadow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_c_main  <= MAIN_RST_C;
      r_c_post  <= '0;
      r_s_main  <= MAIN_RST_C;
      r_s_post  <= '0;
`ifdef PAM4_TX_FFE_PRECURSOR_EN
      r_c_pre   <= '0;
      r_s_pre   <= '0;
`endif
      r_pending <= 1'b0;
    end else begin
      if (symbol_in_valid && r_pending) begin
        r_c_main <= r_s_main;
        r_c_post <= r_s_post;
`ifdef PAM4_TX_FFE_PRECURSOR_EN
        r_c_pre  <= r_s_pre;
`endif
      end
      if (coef_load) begin
        r_s_main  <= coef_main;
        r_s_post  <= coef_post;
`ifdef PAM4_TX_FFE_PRECURSOR_EN
        r_s_pre   <= coef_pre;
`endif
        r_pending <= 1'b1;
      end else if (symbol_in_valid) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign coef_pending     = r_pending;
  assign sample_out       = r_sample;
  assign sample_out_valid = r_valid;
  assign sat              = r_sat;

endmodule

// File: tb/tb_pam4_tx_ffe.sv
// Self-checking bench for pam4_tx_ffe: directed scenarios plus randomized traffic
// compared every cycle against a symbol-history reference model.
module tb_pam4_tx_ffe;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] symbol_in;
  logic       symbol_in_valid;
  logic [7:0] coef_pre;
  logic [7:0] coef_main;
  logic [7:0] coef_post;
  logic       coef_load;
  logic       coef_pending;
  logic [9:0] sample_out;
  logic       sample_out_valid;
  logic       sat;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_hist[$];
  int m_act[3];
  int m_shd[3];
  bit m_pend;
  int m_sample;
  bit m_valid;
  bit m_sat;

  always #5 clk = ~clk;

  pam4_tx_ffe #(.COEF_W(8), .OUT_W(10), .MAIN_RST(64)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .symbol_in        (symbol_in),
    .symbol_in_valid  (symbol_in_valid),
    .coef_pre         (coef_pre),
    .coef_main        (coef_main),
    .coef_post        (coef_post),
    .coef_load        (coef_load),
    .coef_pending     (coef_pending),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .sat              (sat)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies the rules of the block to the inputs present before the coming edge.
  task automatic model_step();
    int x, d1, d2, sum;
    if (!rstn) begin
      m_hist.delete();
      m_act    = '{0, 64, 0};
      m_shd    = m_act;
      m_pend   = 0;
      m_sample = 0;
      m_valid  = 0;
      m_sat    = 0;
    end else begin
      m_valid = symbol_in_valid;
      if (symbol_in_valid) begin
        x  = 2 * int'(symbol_in) - 3;
        d1 = (m_hist.size() > 0) ? m_hist[0] : 0;
        d2 = (m_hist.size() > 1) ? m_hist[1] : 0;
`ifdef PAM4_TX_FFE_PRECURSOR_EN
        sum = m_act[0] * x + m_act[1] * d1 + m_act[2] * d2;
`else
        sum = m_act[1] * x + m_act[2] * d1;
        d2  = 0;
`endif
        m_sat    = (sum > 511) || (sum < -512);
        m_sample = (sum > 511) ? 511 : (sum < -512) ? -512 : sum;
        m_hist.push_front(x);
        if (m_hist.size() > 2) void'(m_hist.pop_back());
        if (m_pend) m_act = m_shd;
      end
      if (coef_load) begin
        m_shd  = '{int'($signed(coef_pre)), int'($signed(coef_main)), int'($signed(coef_post))};
        m_pend = 1;
      end else if (symbol_in_valid) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".valid"},   32'(sample_out_valid), 32'(m_valid));
    check({tag, ".pending"}, 32'(coef_pending),     32'(m_pend));
    check({tag, ".sample"},  32'($signed(sample_out)), m_sample);
    check({tag, ".sat"},     32'(sat),              32'(m_sat));
  endtask

  task automatic drive(input string tag, input bit r, input bit v,
                       input logic [1:0] s, input bit ld);
    rstn            = r;
    symbol_in_valid = v;
    symbol_in       = s;
    coef_load       = ld;
    tick(tag);
    coef_load       = 1'b0;
    symbol_in_valid = 1'b0;
  endtask

  task automatic set_taps(input int p, input int m, input int q);
    coef_pre  = 8'(p);
    coef_main = 8'(m);
    coef_post = 8'(q);
  endtask

  initial begin
    int exp_a[4];
    logic [1:0] seq_a[4];
    rstn = 1'b0; symbol_in = 2'b00; symbol_in_valid = 1'b0; coef_load = 1'b0;
    set_taps(0, 0, 0);

    drive("rst0", 0, 0, 2'b00, 0);
    drive("rst1", 0, 1, 2'b11, 1);
    check("rst.sample", 32'($signed(sample_out)), 0);
    check("rst.pending", 32'(coef_pending), 0);
    check("rst.valid", 32'(sample_out_valid), 0);

    // reset taps, back-to-back symbols
    seq_a = '{2'b00, 2'b11, 2'b01, 2'b10};
    exp_a = '{-192, 192, -64, 64};
    for (int i = 0; i < 4; i++) begin
      drive("b2b", 1, 1, seq_a[i], 0);
      check("b2b.const", 32'($signed(sample_out)), exp_a[i]);
      check("b2b.vld", 32'(sample_out_valid), 1);
    end
    drive("hold", 1, 0, 2'b00, 0);
    check("hold.const", 32'($signed(sample_out)), 64);

    // post-cursor load
    drive("rstB", 0, 0, 2'b00, 0);
    set_taps(0, 64, -16);
    drive("ldpost", 1, 0, 2'b00, 1);
    check("ldpost.pend", 32'(coef_pending), 1);
    drive("post0", 1, 1, 2'b11, 0);
    check("post0.const", 32'($signed(sample_out)), 192);
    check("post0.pend", 32'(coef_pending), 0);
    drive("post1", 1, 1, 2'b11, 0);
    check("post1.const", 32'($signed(sample_out)), 144);
    drive("post2", 1, 1, 2'b00, 0);
    check("post2.const", 32'($signed(sample_out)), -240);

    // saturation both ways
    drive("rstC", 0, 0, 2'b00, 0);
    set_taps(127, 127, 127);
    drive("ldsat", 1, 0, 2'b00, 1);
    drive("sat0", 1, 1, 2'b11, 0);
    drive("sat1", 1, 1, 2'b11, 0);
    drive("sat2", 1, 1, 2'b11, 0);
    check("sat2.const", 32'($signed(sample_out)), 511);
    check("sat2.flag", 32'(sat), 1);
    drive("sat3", 1, 1, 2'b00, 0);
    drive("sat4", 1, 1, 2'b00, 0);
    check("sat4.const", 32'($signed(sample_out)), -512);
    check("sat4.flag", 32'(sat), 1);

    // load in the same cycle as a valid
    drive("rstD", 0, 0, 2'b00, 0);
    set_taps(0, 32, 0);
    drive("same0", 1, 1, 2'b11, 1);
    check("same0.const", 32'($signed(sample_out)), 192);
    check("same0.pend", 32'(coef_pending), 1);
    drive("same1", 1, 1, 2'b11, 0);
    check("same1.const", 32'($signed(sample_out)), 192);
    check("same1.pend", 32'(coef_pending), 0);
    drive("same2", 1, 1, 2'b11, 0);
    check("same2.const", 32'($signed(sample_out)), 96);

    // reset mid-stream with a pending load and valid high
    set_taps(5, -40, 9);
    drive("mid0", 1, 1, 2'b01, 1);
    drive("mid1", 0, 1, 2'b11, 0);
    check("mid1.valid", 32'(sample_out_valid), 0);
    check("mid1.sample", 32'($signed(sample_out)), 0);
    check("mid1.pend", 32'(coef_pending), 0);
    drive("mid2", 1, 1, 2'b11, 0);
    check("mid2.const", 32'($signed(sample_out)), 192);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rstn            = ($urandom_range(0, 199) != 0);
      symbol_in_valid = ($urandom_range(0, 3) != 0);
      symbol_in       = 2'($urandom_range(0, 3));
      coef_load       = ($urandom_range(0, 11) == 0);
      if (coef_load) begin
        if ($urandom_range(0, 3) == 0) set_taps(127, 127, 127);
        else set_taps(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)));
      end
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
